// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default ID/EX payload layout for pipe_stage
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY, FULL, FULL_SKID} state_t;
    localparam int ALUOP_W = 8;
    localparam int ALUSEL_W = 3;
    localparam int REG_W = 32;
    localparam int WD_W = 5;
    localparam int WREG_W = 1;
    localparam int WREG_OFF = 0;
    localparam int WD_OFF = WREG_OFF + WREG_W;
    localparam int REG2_OFF = WD_OFF + WD_W;
    localparam int REG1_OFF = REG2_OFF + REG_W;
    localparam int ALUSEL_OFF = REG1_OFF + REG_W;
    localparam int ALUOP_OFF = ALUSEL_OFF + ALUSEL_W;
    localparam int PAYLOAD_W = ALUOP_OFF + ALUOP_W;
    localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    // clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (inc && !(&q)) q <= q + CNT_W'(1);
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with optional skid, flush and perf counters
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_W,
    parameter bit SKID = 1'b1,
    parameter int CNT_W = 16,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_PAYLOAD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_bubble
);
    state_t state, state_nx;
    logic [DATA_W-1:0] main_q, main_nx, skid_q;
    logic in_fire, out_fire;

    assign out_valid = state != EMPTY;
    assign out_data = out_valid ? main_q : NOP_VAL;
    assign in_fire = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            assign in_ready = (state != FULL_SKID) & !rst;
            // skid catches the one beat that arrives while the output is blocked
            always_ff @(posedge clk or posedge rst)
                if (rst) skid_q <= NOP_VAL;
                else if (flush) skid_q <= NOP_VAL;
                else if (state == FULL && in_fire && !out_fire) skid_q <= in_data;
        end else begin : g_noskid
            assign in_ready = (out_ready | !out_valid) & !rst;
            assign skid_q = NOP_VAL;
        end
    endgenerate

    // next state and main payload; flush overrides every handshake event
    always_comb begin
        state_nx = state;
        main_nx = main_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx = NOP_VAL;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx = FULL;
                    main_nx = in_data;
                end
                FULL: if (in_fire && out_fire) main_nx = in_data;
                    else if (in_fire) state_nx = FULL_SKID;
                    else if (out_fire) state_nx = EMPTY;
                FULL_SKID: if (out_fire) begin
                    state_nx = FULL;
                    main_nx = skid_q;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // state and main payload registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= EMPTY;
            main_q <= NOP_VAL;
        end else begin
            state <= state_nx;
            main_q <= main_nx;
        end

    sat_cnt #(.CNT_W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(out_valid & !out_ready), .q(cnt_stall)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_bubble (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(!out_valid & !rst), .q(cnt_bubble)
    );
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: randomized and directed checks of pipe_stage against a queue model
module tb_pipe_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [80:0] a_in_data = '0, a_out_data;
    logic        a_flush = 1'b0, a_cnt_clr = 1'b0;
    logic [15:0] a_cnt_stall, a_cnt_bubble;

    logic        b_in_ready, b_out_valid, b_cnt_clr = 1'b0;
    logic [80:0] b_out_data;
    logic [3:0]  b_cnt_stall, b_cnt_bubble;

    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [80:0] c_in_data = '0, c_out_data;
    logic [15:0] c_cnt_stall, c_cnt_bubble;

    pipe_stage u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .cnt_clr(a_cnt_clr), .cnt_stall(a_cnt_stall), .cnt_bubble(a_cnt_bubble)
    );

    pipe_stage #(.CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(b_in_ready), .in_data(81'd0),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
        .flush(1'b0), .cnt_clr(b_cnt_clr), .cnt_stall(b_cnt_stall), .cnt_bubble(b_cnt_bubble)
    );

    pipe_stage #(.SKID(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .flush(1'b0), .cnt_clr(1'b0), .cnt_stall(c_cnt_stall), .cnt_bubble(c_cnt_bubble)
    );

    int checks = 0;
    int failures = 0;
    logic [80:0] mq[$];
    int m_stall = 0;
    int m_bubble = 0;

    task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock of stage A: drive, compare against the queue model, advance the model
    task automatic step_a(input logic iv, input logic [80:0] d, input logic ordy,
                          input logic fl, input logic clr);
        logic exp_ready, exp_ov, in_f, out_f;
        logic [80:0] exp_od;
        a_in_valid = iv;
        a_in_data = d;
        a_out_ready = ordy;
        a_flush = fl;
        a_cnt_clr = clr;
        #1;
        exp_ready = mq.size() < 2;
        exp_ov = mq.size() > 0;
        exp_od = exp_ov ? mq[0] : 81'd0;
        chk("a_in_ready", a_in_ready, exp_ready);
        chk("a_out_valid", a_out_valid, exp_ov);
        chk("a_out_data", a_out_data, exp_od);
        chk("a_cnt_stall", a_cnt_stall, m_stall);
        chk("a_cnt_bubble", a_cnt_bubble, m_bubble);
        @(posedge clk);
        in_f = iv & exp_ready;
        out_f = exp_ov & ordy;
        if (clr) begin
            m_stall = 0;
            m_bubble = 0;
        end else begin
            if (exp_ov && !ordy && m_stall < 65535) m_stall++;
            if (!exp_ov && m_bubble < 65535) m_bubble++;
        end
        if (fl) mq.delete();
        else begin
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(d);
        end
        #1;
    endtask

    initial begin
        logic [80:0] rd;
        // reset state
        #1;
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_data", a_out_data, 81'd0);
        chk("rst_cnt_bubble", a_cnt_bubble, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // idle cycles: saturation of the 4-bit counter on instance B
        for (int i = 0; i < 10; i++) step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        chk("b_bubble_10", b_cnt_bubble, 4'd10);
        for (int i = 0; i < 10; i++) step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        chk("b_bubble_sat", b_cnt_bubble, 4'd15);
        b_cnt_clr = 1'b1;
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        b_cnt_clr = 1'b0;
        chk("b_bubble_clr", b_cnt_bubble, 4'd0);
        // SKID=0 instance C: in_ready follows out_ready combinationally
        c_in_valid = 1'b1;
        c_in_data = 81'hA;
        c_out_ready = 1'b0;
        #1;
        chk("c_ready_empty", c_in_ready, 1'b1);
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        c_in_data = 81'hB;
        #1;
        chk("c_out_valid", c_out_valid, 1'b1);
        chk("c_out_a", c_out_data, 81'hA);
        chk("c_ready_blocked", c_in_ready, 1'b0);
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        chk("c_hold_a", c_out_data, 81'hA);
        c_out_ready = 1'b1;
        #1;
        chk("c_ready_same_cycle", c_in_ready, 1'b1);
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        c_in_valid = 1'b0;
        chk("c_out_b", c_out_data, 81'hB);
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        chk("c_drained", c_out_valid, 1'b0);
        // streaming 1..8 at full rate
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step_a(1'b1, 81'(i), 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        chk("stream_stall", a_cnt_stall, 16'd0);
        // backpressure for 3 cycles mid-stream
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b1);
        step_a(1'b1, 81'h11, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 81'h12, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 81'h13, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 81'h14, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 81'h15, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 81'h15, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_stall3", a_cnt_stall, 16'd3);
        // flush while FULL_SKID with a beat presented
        step_a(1'b1, 81'h21, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 81'h22, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 81'h23, 1'b0, 1'b1, 1'b0);
        step_a(1'b1, 81'h24, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 81'd0, 1'b1, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rd = {17'($urandom), $urandom, $urandom};
            step_a(1'($urandom_range(0, 1)), rd, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 24) == 0, $urandom_range(0, 60) == 0);
        end
        // async reset between edges while FULL
        step_a(1'b1, 81'h5A5A, 1'b0, 1'b0, 1'b0);
        a_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", a_out_valid, 1'b0);
        chk("arst_out_data", a_out_data, 81'd0);
        chk("arst_in_ready", a_in_ready, 1'b0);
        chk("arst_stall", a_cnt_stall, 16'd0);
        chk("arst_bubble", a_cnt_bubble, 16'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_ready", a_in_ready, 1'b0);
        chk("arst_hold_bubble", a_cnt_bubble, 16'd0);
        rst = 1'b0;
        mq.delete();
        m_stall = 0;
        m_bubble = 0;
        for (int i = 0; i < 40; i++) begin
            rd = {17'($urandom), $urandom, $urandom};
            step_a(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
